// File: rtl/game_stat_ctrl.sv
// Whack-a-mole round state machine, one-second countdown and hit/escape statistics.
// Optional macro COMBO_BONUS_EN: a hit scores 2 points once the running combo is at least 4.
module game_stat_ctrl #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned GAME_TIME  = 60,
    parameter int unsigned LEVEL_STEP = 10,
    parameter int unsigned MAX_LEVEL  = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       hit,
    input  logic       escape,
    output logic [1:0] state,
    output logic [9:0] timer,
    output logic [9:0] score,
    output logic [7:0] kill,
    output logic [7:0] runaway,
    output logic [7:0] combo,
    output logic [3:0] level
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StPause = 2'd2,
        StOver  = 2'd3
    } state_e;

    localparam logic [9:0]  TimeInit  = 10'(GAME_TIME);
    localparam logic [3:0]  LevelMax  = 4'(MAX_LEVEL);
    localparam logic [31:0] PresWrap  = 32'(CLK_FREQ - 1);
    localparam logic [31:0] LevelWrap = 32'(LEVEL_STEP - 1);
    localparam logic [9:0]  ScoreMax  = 10'd999;

    state_e      state_q, state_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] level_cnt_q, level_cnt_d;
    logic [9:0]  timer_q, timer_d;
    logic [9:0]  score_q, score_d;
    logic [7:0]  kill_q, kill_d;
    logic [7:0]  runaway_q, runaway_d;
    logic [7:0]  combo_q, combo_d;
    logic [3:0]  level_q, level_d;

    logic        in_play, launch, sec_tick, hit_ok, esc_ok;
    logic [1:0]  score_inc;
    logic [10:0] score_sum;

    assign in_play  = (state_q == StPlay);
    assign launch   = start && ((state_q == StIdle) || (state_q == StOver));
    assign sec_tick = in_play && (presc_q == PresWrap);
    assign hit_ok   = in_play && hit;
    assign esc_ok   = in_play && escape;

    // Increment depends on the combo value before this cycle's update.
`ifdef COMBO_BONUS_EN
    assign score_inc = (combo_q >= 8'd4) ? 2'd2 : 2'd1;
`else
    assign score_inc = 2'd1;
`endif
    assign score_sum = {1'b0, score_q} + {9'd0, score_inc};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StOver: if (start) state_d = StPlay;
            // Running out of time beats a simultaneous pause request.
            StPlay: begin
                if (sec_tick && (timer_q == 10'd1)) state_d = StOver;
                else if (pause)                     state_d = StPause;
            end
            StPause: if (pause) state_d = StPlay;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        presc_d     = presc_q;
        level_cnt_d = level_cnt_q;
        timer_d     = timer_q;
        score_d     = score_q;
        kill_d      = kill_q;
        runaway_d   = runaway_q;
        combo_d     = combo_q;
        level_d     = level_q;
        if (launch) begin
            presc_d     = '0;
            level_cnt_d = '0;
            timer_d     = TimeInit;
            score_d     = '0;
            kill_d      = '0;
            runaway_d   = '0;
            combo_d     = '0;
            level_d     = 4'd1;
        end else begin
            if (in_play) presc_d = sec_tick ? '0 : presc_q + 32'd1;
            if (sec_tick) timer_d = timer_q - 10'd1;
            if (hit_ok) begin
                if (kill_q != 8'hFF)  kill_d  = kill_q + 8'd1;
                if (combo_q != 8'hFF) combo_d = combo_q + 8'd1;
                score_d = (score_sum > {1'b0, ScoreMax}) ? ScoreMax : score_sum[9:0];
                if (level_cnt_q >= LevelWrap) begin
                    level_cnt_d = '0;
                    if (level_q < LevelMax) level_d = level_q + 4'd1;
                end else begin
                    level_cnt_d = level_cnt_q + 32'd1;
                end
            end
            if (esc_ok) begin
                if (runaway_q != 8'hFF) runaway_d = runaway_q + 8'd1;
                combo_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            level_cnt_q <= '0;
            timer_q     <= TimeInit;
            score_q     <= '0;
            kill_q      <= '0;
            runaway_q   <= '0;
            combo_q     <= '0;
            level_q     <= 4'd1;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            level_cnt_q <= level_cnt_d;
            timer_q     <= timer_d;
            score_q     <= score_d;
            kill_q      <= kill_d;
            runaway_q   <= runaway_d;
            combo_q     <= combo_d;
            level_q     <= level_d;
        end
    end

    assign state   = state_q;
    assign timer   = timer_q;
    assign score   = score_q;
    assign kill    = kill_q;
    assign runaway = runaway_q;
    assign combo   = combo_q;
    assign level   = level_q;

endmodule
